mips_control_unit: RTL and testbench

- Multi-cycle MIPS main control FSM and ALU decoder.
- Generates every datapath control strobe and mux select for `MIPS_Multi_Cycle` from the instruction opcode/funct fields, replacing hand-sequenced control stimulus.
- Generalised over the IF/ID/EX/WB sequence used for `addi`/`add` to cover R-type ALU ops, `lw`, `sw`, `beq`, `bne`.
- Adds a `mem_ready` handshake for variable-latency memory.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/mips_control_unit_if.sv | 42 ++++
 rtl/mips_alu_decoder.sv | 28 ++
 rtl/mips_control_unit.sv | 154 +++++++++++++++
 tb/tb_mips_control_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: FSM state encoding, opcode/funct fields,
// ALU operation codes and ALUSrcB select values.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    ALU_WB   = 4'd7,
    ADDI_EX  = 4'd8,
    BRANCH   = 4'd9
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and memory handshake in,
// every datapath strobe / mux select out. master = control unit, slave = datapath.
interface mips_control_unit_if #(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 4
);

  logic [OP_W-1:0]      Op;
  logic [FUNCT_W-1:0]   Funct;
  logic                 mem_ready;
  logic                 IorD;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 BranchEq;
  logic                 BranchNeq;
  logic                 PCSrc;
  logic                 ALUSrcA;
  logic                 RegWrite;
  logic                 MemtoReg;
  logic                 RegDst;
  logic [1:0]           ALUSrcB;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal_op;
  logic [3:0]           state_o;

  modport master (
    input  Op, Funct, mem_ready,
    output IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc,
           ALUSrcA, RegWrite, MemtoReg, RegDst, ALUSrcB, ALUControl,
           illegal_op, state_o
  );

  modport slave (
    output Op, Funct, mem_ready,
    input  IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc,
           ALUSrcA, RegWrite, MemtoReg, RegDst, ALUSrcB, ALUControl,
           illegal_op, state_o
  );

endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational R-type Funct -> ALUControl map; unknown functs fall back to ADD
// and raise illegal_funct.
module mips_alu_decoder
  import mips_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 4
) (
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 illegal_funct
);

  always_comb begin
    alu_ctrl      = ALUCTRL_W'(ALU_ADD);
    illegal_funct = 1'b0;
    case (funct)
      FUNCT_W'(FN_ADD): alu_ctrl = ALUCTRL_W'(ALU_ADD);
      FUNCT_W'(FN_SUB): alu_ctrl = ALUCTRL_W'(ALU_SUB);
      FUNCT_W'(FN_AND): alu_ctrl = ALUCTRL_W'(ALU_AND);
      FUNCT_W'(FN_OR):  alu_ctrl = ALUCTRL_W'(ALU_OR);
      FUNCT_W'(FN_NOR): alu_ctrl = ALUCTRL_W'(ALU_NOR);
      FUNCT_W'(FN_SLT): alu_ctrl = ALUCTRL_W'(ALU_SLT);
      default:          illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Multi-cycle MIPS main control FSM; 3-5 cycles per instruction plus one per mem_ready=0
// cycle in FETCH/MEMRD/MEMWR. Define MIPS_CTRL_BNE_EN to decode bne, else it is illegal.
module mips_control_unit
  import mips_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  mips_control_unit_if.master ctrl
);

  ctrl_state_t          state;
  ctrl_state_t          state_nxt;
  logic                 rtype_wb;
  logic [ALUCTRL_W-1:0] funct_alu;
  logic                 illegal_funct;
  logic                 op_rtype, op_lw, op_sw, op_addi, op_beq, op_bne, op_legal;

  mips_alu_decoder #(
    .FUNCT_W  (FUNCT_W),
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .funct        (ctrl.Funct),
    .alu_ctrl     (funct_alu),
    .illegal_funct(illegal_funct)
  );

  assign op_rtype = (ctrl.Op == OP_W'(OP_RTYPE));
  assign op_lw    = (ctrl.Op == OP_W'(OP_LW));
  assign op_sw    = (ctrl.Op == OP_W'(OP_SW));
  assign op_addi  = (ctrl.Op == OP_W'(OP_ADDI));
  assign op_beq   = (ctrl.Op == OP_W'(OP_BEQ));
`ifdef MIPS_CTRL_BNE_EN
  assign op_bne   = (ctrl.Op == OP_W'(OP_BNE));
`else
  assign op_bne   = 1'b0;
`endif
  assign op_legal = op_rtype | op_lw | op_sw | op_addi | op_beq | op_bne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Remembers which EX state fed ALU_WB so it can pick rd (R-type) or rt (addi).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rtype_wb <= 1'b0;
    end else if (state == RTYPE_EX) begin
      rtype_wb <= 1'b1;
    end else if (state == ADDI_EX) begin
      rtype_wb <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = ctrl.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (op_rtype)              state_nxt = RTYPE_EX;
        else if (op_lw || op_sw)   state_nxt = MEMADR;
        else if (op_addi)          state_nxt = ADDI_EX;
        else if (op_beq || op_bne) state_nxt = BRANCH;
        else                       state_nxt = FETCH;
      end
      MEMADR:   state_nxt = op_lw ? MEMRD : MEMWR;
      MEMRD:    state_nxt = ctrl.mem_ready ? MEMWB : MEMRD;
      MEMWB:    state_nxt = FETCH;
      MEMWR:    state_nxt = ctrl.mem_ready ? FETCH : MEMWR;
      RTYPE_EX: state_nxt = illegal_funct ? FETCH : ALU_WB;
      ADDI_EX:  state_nxt = ALU_WB;
      ALU_WB:   state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      default:  state_nxt = FETCH;
    endcase
  end

  // Reset parks the state in FETCH, so only the mem_ready-gated strobes need the extra gate.
  always_comb begin
    ctrl.IorD       = 1'b0;
    ctrl.MemWrite   = 1'b0;
    ctrl.IRWrite    = 1'b0;
    ctrl.PCWrite    = 1'b0;
    ctrl.BranchEq   = 1'b0;
    ctrl.BranchNeq  = 1'b0;
    ctrl.PCSrc      = 1'b0;
    ctrl.ALUSrcA    = 1'b0;
    ctrl.RegWrite   = 1'b0;
    ctrl.MemtoReg   = 1'b0;
    ctrl.RegDst     = 1'b0;
    ctrl.ALUSrcB    = SRCB_REG;
    ctrl.ALUControl = '0;
    ctrl.illegal_op = 1'b0;
    case (state)
      FETCH: begin
        ctrl.ALUSrcB    = SRCB_FOUR;
        ctrl.ALUControl = ALUCTRL_W'(ALU_ADD);
        ctrl.IRWrite    = ctrl.mem_ready & reset;
        ctrl.PCWrite    = ctrl.mem_ready & reset;
      end
      DECODE: begin
        ctrl.ALUSrcB    = SRCB_IMM_SH2;
        ctrl.ALUControl = ALUCTRL_W'(ALU_ADD);
        ctrl.illegal_op = ~op_legal & reset;
      end
      MEMADR: begin
        ctrl.ALUSrcA    = 1'b1;
        ctrl.ALUSrcB    = SRCB_IMM;
        ctrl.ALUControl = ALUCTRL_W'(ALU_ADD);
      end
      MEMRD: ctrl.IorD = 1'b1;
      MEMWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemtoReg = 1'b1;
      end
      MEMWR: begin
        ctrl.IorD     = 1'b1;
        ctrl.MemWrite = 1'b1;
      end
      RTYPE_EX: begin
        ctrl.ALUSrcA    = 1'b1;
        ctrl.ALUControl = funct_alu;
        ctrl.illegal_op = illegal_funct & reset;
      end
      ADDI_EX: begin
        ctrl.ALUSrcA    = 1'b1;
        ctrl.ALUSrcB    = SRCB_IMM;
        ctrl.ALUControl = ALUCTRL_W'(ALU_ADD);
      end
      ALU_WB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.RegDst   = rtype_wb;
      end
      BRANCH: begin
        ctrl.ALUSrcA    = 1'b1;
        ctrl.ALUControl = ALUCTRL_W'(ALU_SUB);
        ctrl.PCSrc      = 1'b1;
        ctrl.BranchEq   = op_beq;
        ctrl.BranchNeq  = op_bne;
      end
      default: ;
    endcase
  end

  assign ctrl.state_o = state;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit: per-cycle expected control vectors
// (state|strobes|ALUSrcB|ALUControl|illegal_op) hand-written per instruction.
module tb_mips_control_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_control_unit_if #(.OP_W(6), .FUNCT_W(6), .ALUCTRL_W(4)) bus ();

  mips_control_unit #(.OP_W(6), .FUNCT_W(6), .ALUCTRL_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .ctrl (bus.master)
  );

  // Vector layout: state[21:18] | IorD MemWrite IRWrite PCWrite BranchEq BranchNeq
  // PCSrc ALUSrcA RegWrite MemtoReg RegDst [17:7] | ALUSrcB[6:5] | ALUControl[4:1] | illegal_op[0]
  localparam logic [21:0] V_FETCH   = {4'd0, 11'b00110000000, 2'b01, 4'b0010, 1'b0};
  localparam logic [21:0] V_FETCHW  = {4'd0, 11'b00000000000, 2'b01, 4'b0010, 1'b0};
  localparam logic [21:0] V_DECODE  = {4'd1, 11'b00000000000, 2'b11, 4'b0010, 1'b0};
  localparam logic [21:0] V_DEC_ILL = {4'd1, 11'b00000000000, 2'b11, 4'b0010, 1'b1};
  localparam logic [21:0] V_MEMADR  = {4'd2, 11'b00000001000, 2'b10, 4'b0010, 1'b0};
  localparam logic [21:0] V_MEMRD   = {4'd3, 11'b10000000000, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] V_MEMWB   = {4'd4, 11'b00000000110, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] V_MEMWR   = {4'd5, 11'b11000000000, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] V_WB_R    = {4'd7, 11'b00000000101, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] V_WB_I    = {4'd7, 11'b00000000100, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] V_ADDI    = {4'd8, 11'b00000001000, 2'b10, 4'b0010, 1'b0};
  localparam logic [21:0] V_BEQ     = {4'd9, 11'b00001011000, 2'b00, 4'b0110, 1'b0};
  localparam logic [21:0] V_BNE     = {4'd9, 11'b00000111000, 2'b00, 4'b0110, 1'b0};

  function automatic logic [21:0] ctl_vec();
    return {bus.state_o, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite,
            bus.BranchEq, bus.BranchNeq, bus.PCSrc, bus.ALUSrcA, bus.RegWrite,
            bus.MemtoReg, bus.RegDst, bus.ALUSrcB, bus.ALUControl, bus.illegal_op};
  endfunction

  task automatic test_reset();
    bus.Op = 6'h08; bus.Funct = 6'h20; bus.mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCHW) begin
      failures++; $display("FAIL reset_t1 got=%h exp=%h", ctl_vec(), V_FETCHW);
    end
    #7;
    checks++;
    if (ctl_vec() !== V_FETCHW) begin
      failures++; $display("FAIL reset_after_edge got=%h exp=%h", ctl_vec(), V_FETCHW);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_addi();
    logic [21:0] ev [4];
    ev = '{V_FETCH, V_DECODE, V_ADDI, V_WB_I};
    bus.Op = 6'h08;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL addi cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn [6];
    logic [3:0]  al [6];
    logic [21:0] ev [4];
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    al = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    for (int k = 0; k < 6; k++) begin
      bus.Op = 6'h00; bus.Funct = fn[k];
      ev = '{V_FETCH, V_DECODE, {4'd6, 11'b00000001000, 2'b00, al[k], 1'b0}, V_WB_R};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); bus.mem_ready = 1'b1; #1;
        checks++;
        if (ctl_vec() !== ev[i]) begin
          failures++; $display("FAIL rtype fn=%h cyc%0d got=%h exp=%h", fn[k], i, ctl_vec(), ev[i]);
        end
      end
    end
  endtask

  task automatic test_illegal_funct();
    logic [21:0] ev [4];
    logic        mr [4];
    ev = '{V_FETCH, V_DECODE, {4'd6, 11'b00000001000, 2'b00, 4'b0010, 1'b1}, V_FETCHW};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.Op = 6'h00; bus.Funct = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL illegal_funct cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
  endtask

  task automatic test_illegal_op();
    logic [21:0] ev [3];
    logic        mr [3];
    ev = '{V_FETCH, V_DEC_ILL, V_FETCHW};
    mr = '{1'b1, 1'b1, 1'b0};
    bus.Op = 6'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL illegal_op cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [21:0] ev [10];
    logic        mr [10];
    int          irw = 0;
    ev = '{V_FETCHW, V_FETCHW, V_FETCH, V_DECODE, V_MEMADR,
           V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.Op = 6'h23;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      if (bus.IRWrite === 1'b1) irw++;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL lw cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
    checks++;
    if (irw !== 1) begin
      failures++; $display("FAIL lw_irwrite_count got=%0d exp=1", irw);
    end
  endtask

  task automatic test_sw_wait();
    logic [21:0] ev [5];
    logic        mr [5];
    int          mw = 0;
    ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.Op = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      if (bus.MemWrite === 1'b1) mw++;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL sw cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
    checks++;
    if (mw !== 2) begin
      failures++; $display("FAIL sw_memwrite_count got=%0d exp=2", mw);
    end
  endtask

  task automatic test_branch();
    logic [21:0] ev [3];
    logic        mr [3];
    ev = '{V_FETCH, V_DECODE, V_BEQ};
    mr = '{1'b1, 1'b1, 1'b1};
    bus.Op = 6'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL beq cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
`ifdef MIPS_CTRL_BNE_EN
    ev = '{V_FETCH, V_DECODE, V_BNE};
`else
    ev = '{V_FETCH, V_DEC_ILL, V_FETCHW};
    mr = '{1'b1, 1'b1, 1'b0};
`endif
    bus.Op = 6'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL bne cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] ev [8];
    bus.Op = 6'h00; bus.Funct = 6'h25;
    ev = '{V_FETCH, V_DECODE, {4'd6, 11'b00000001000, 2'b00, 4'b0001, 1'b0}, V_WB_R,
           V_FETCH, V_DECODE, V_ADDI, V_WB_I};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.mem_ready = 1'b1;
      if (i == 4) bus.Op = 6'h08;
      #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL b2b cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_memrd();
    logic [21:0] ev [4];
    logic        mr [4];
    ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.Op = 6'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.mem_ready = mr[i]; #1;
      checks++;
      if (ctl_vec() !== ev[i]) begin
        failures++; $display("FAIL rst_memrd cyc%0d got=%h exp=%h", i, ctl_vec(), ev[i]);
      end
    end
    #2;
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCHW) begin
      failures++; $display("FAIL rst_async got=%h exp=%h", ctl_vec(), V_FETCHW);
    end
    @(negedge clk); #1;
    checks++;
    if (ctl_vec() !== V_FETCHW) begin
      failures++; $display("FAIL rst_held got=%h exp=%h", ctl_vec(), V_FETCHW);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH) begin
      failures++; $display("FAIL rst_release got=%h exp=%h", ctl_vec(), V_FETCH);
    end
    @(negedge clk); #1;
    checks++;
    if (ctl_vec() !== V_DECODE) begin
      failures++; $display("FAIL rst_first_fetch got=%h exp=%h", ctl_vec(), V_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_illegal_funct();
    test_illegal_op();
    test_lw_wait();
    test_sw_wait();
    test_branch();
    test_back_to_back();
    test_reset_mid_memrd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
